// File: rtl/memips_pkg.sv
// Shared MEMIPS types and architectural constants used by the front-end blocks.
package memips_pkg;

    typedef logic [31:0] word_t;

    localparam word_t RESET_VECTOR = 32'hBFC0_0000;
    localparam word_t NOP_INSTR    = 32'h0000_0000;

endpackage

// File: rtl/if_fifo2.sv
// Two-entry FIFO with synchronous flush; flush wins over push and pop in the same cycle.
module if_fifo2 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = mem[rd_ptr];

    // Storage is cleared on reset so the presented outputs read as zero until the first write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: PC generation, one-cycle memory, 2-entry output buffer, redirects.
// Optional macro IF_ALIGN_CHECK_EN turns misaligned redirects into an address-error entry.
module if_fetch_unit
    import memips_pkg::*;
#(
    parameter word_t RESET_PC   = RESET_VECTOR,
    parameter int    FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
`ifdef IF_ALIGN_CHECK_EN
    output logic [31:0] if_instr,
    output logic        if_exc_adel
`else
    output logic [31:0] if_instr
`endif
);

`ifdef IF_ALIGN_CHECK_EN
    localparam int ENTRY_W = 65;
`else
    localparam int ENTRY_W = 64;
`endif

    localparam logic [2:0] CAP = 3'(FIFO_DEPTH);

    word_t               pc;
    word_t               req_pc;
    word_t               br_pc;
    logic                inflight;
    logic                pop;
    logic                push;
    logic                fetch_ok;
    logic [1:0]          count;
    logic [2:0]          occ;
    logic [ENTRY_W-1:0]  push_data;
    logic [ENTRY_W-1:0]  head;

    assign pop       = if_valid & id_ready;
    assign occ       = {1'b0, count} + {2'b00, inflight};
    assign imem_addr = pc;
    assign imem_req  = rst_n & ~br_valid & fetch_ok & (occ < (CAP + {2'b00, pop}));
    assign if_valid  = (count != 2'd0);

`ifdef IF_ALIGN_CHECK_EN
    logic fetch_stop;
    logic exc_pend;
    logic br_misaligned;

    assign br_pc         = br_target;
    assign br_misaligned = br_valid && (br_target[1:0] != 2'b00);
    assign fetch_ok      = ~fetch_stop;
    assign push          = (inflight | exc_pend) & ~br_valid;
    assign push_data     = exc_pend ? {1'b1, pc, NOP_INSTR} : {1'b0, req_pc, imem_rdata};
    assign {if_exc_adel, if_pc, if_instr} = head;

    // A misaligned redirect parks the fetcher; only the next redirect can restart it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_stop <= 1'b0;
            exc_pend   <= 1'b0;
        end else if (br_valid) begin
            fetch_stop <= br_misaligned;
            exc_pend   <= br_misaligned;
        end else begin
            exc_pend   <= 1'b0;
        end
    end
`else
    assign br_pc     = br_target & 32'hFFFF_FFFC;
    assign fetch_ok  = 1'b1;
    assign push      = inflight & ~br_valid;
    assign push_data = {req_pc, imem_rdata};
    assign {if_pc, if_instr} = head;
`endif

    // A request issued in a redirect cycle never happens, so inflight simply mirrors imem_req.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                req_pc <= pc;
            end
            if (br_valid) begin
                pc <= br_pc;
            end else if (imem_req) begin
                pc <= pc + 32'd4;
            end
        end
    end

    if_fifo2 #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (br_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

endmodule
